fetch_unit: RTL

- Front-end stage directly upstream of the instruction memory. Owns the PC and drives the memory's combinational read address.
- Each cycle it captures the returned instruction, tagged with its PC, into a small fetch queue.
- The queue feeds decode/rename over a valid/ready handshake.
- A redirect port (branch resolution / squash from the backend) flushes the queue and reloads the PC.

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_queue.sv | 70 +++++++
 rtl/fetch_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared parameters for the fetch front-end: instruction memory geometry,
// instruction width and fetch queue sizing.
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 3
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef FQ_DEPTH
`define FQ_DEPTH 4
`endif
`ifndef FQ_SIZE_LOG
`define FQ_SIZE_LOG 2
`endif
`ifndef FETCH_ENTRY_LEN
`define FETCH_ENTRY_LEN (`MEMI_SIZE_LOG + `INST_LEN)
`endif

package fetch_unit_pkg;
    localparam int PC_W     = `MEMI_SIZE_LOG;
    localparam int INST_W   = `INST_LEN;
    localparam int FQ_DEPTH = `FQ_DEPTH;
    localparam int FQ_LOG   = `FQ_SIZE_LOG;
    localparam int ENTRY_W  = `FETCH_ENTRY_LEN;
endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO used as the fetch queue. Flush empties it in one
// cycle; a full queue may accept an enqueue in the same cycle as a dequeue.
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 3
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef FQ_DEPTH
`define FQ_DEPTH 4
`endif
`ifndef FQ_SIZE_LOG
`define FQ_SIZE_LOG 2
`endif
`ifndef FETCH_ENTRY_LEN
`define FETCH_ENTRY_LEN (`MEMI_SIZE_LOG + `INST_LEN)
`endif

module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DATA_W = `FETCH_ENTRY_LEN,
    parameter int DEPTH  = `FQ_DEPTH,
    parameter int LOG    = `FQ_SIZE_LOG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              enq,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              deq,
    output logic [DATA_W-1:0] head_data,
    output logic [LOG:0]      count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [LOG-1:0]    head;
    logic [LOG-1:0]    tail;

    // Storage is written on enqueue only; its content is meaningless while empty.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= enq_data;
        end
    end

    // Pointer and occupancy bookkeeping, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + LOG'(1);
            end
            if (deq) begin
                head <= head + LOG'(1);
            end
            if (enq && !deq) begin
                count <= count + (LOG+1)'(1);
            end else if (deq && !enq) begin
                count <= count - (LOG+1)'(1);
            end
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front-end: owns the PC, drives the combinational instruction memory
// address, queues {pc, inst} pairs and hands them downstream over valid/ready.
// A redirect flushes the queue and reloads the PC.
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 3
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef FQ_DEPTH
`define FQ_DEPTH 4
`endif
`ifndef FQ_SIZE_LOG
`define FQ_SIZE_LOG 2
`endif
`ifndef FETCH_ENTRY_LEN
`define FETCH_ENTRY_LEN (`MEMI_SIZE_LOG + `INST_LEN)
`endif

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W     = `MEMI_SIZE_LOG,
    parameter int INST_W   = `INST_LEN,
    parameter int FQ_DEPTH = `FQ_DEPTH,
    parameter int FQ_LOG   = `FQ_SIZE_LOG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [FQ_LOG:0]   fq_count
);

    localparam int ENTRY_LEN = PC_W + INST_W;

    logic [PC_W-1:0]      pc;
    logic [ENTRY_LEN-1:0] head_data;
    logic                 full;
    logic                 enq;
    logic                 deq;

    assign imem_addr = pc;
    assign full      = (fq_count == (FQ_LOG+1)'(FQ_DEPTH));
    assign out_valid = (fq_count != '0) && !redirect_valid;
    assign deq       = out_valid && out_ready;
    assign enq       = fetch_en && !redirect_valid && (!full || deq);
    assign out_pc    = head_data[ENTRY_LEN-1:INST_W];
    assign out_inst  = head_data[INST_W-1:0];

    // PC advances only when the current word is actually captured, so a
    // stalled address is simply re-presented until the queue has room.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (enq) begin
            pc <= pc + PC_W'(1);
        end
    end

    fetch_queue #(
        .DATA_W (ENTRY_LEN),
        .DEPTH  (FQ_DEPTH),
        .LOG    (FQ_LOG)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .enq       (enq),
        .enq_data  ({pc, imem_data}),
        .deq       (deq),
        .head_data (head_data),
        .count     (fq_count)
    );

endmodule
